mtbuf_addr_seq: RTL and testbench
=================================

Name: mtbuf_addr_seq

Overview:
- Per-wavefront sequencer for the MTBUF address-calculation datapath in the LSU.
- Accepts one MTBUF issue with a 64-lane exec mask and walks the active lanes.
- Drives the lane index (tid) into the combinational address calculator and the VGPR lane-select mux, then registers each resulting 32-bit address as one memory request.
- Emits requests over a valid/ready handshake at up to one per cycle, and pulses completion after the last request.

Parameters:
- NUM_LANES, 64, lanes per wavefront.
- LANE_W, 6, log2(NUM_LANES).
- ADDR_W, 32, request address width.
- TAG_W, 7, instruction tag width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- issue_valid  in  1  MTBUF instruction offered.
- issue_ready  out  1  sequencer idle; can accept.
- issue_exec  in  NUM_LANES  exec mask; bit i = lane i active.
- issue_tag  in  TAG_W  instruction tag.
- calc_tid  out  LANE_W  lane index to address calc and VGPR lane mux.
- calc_addr  in  ADDR_W  combinational address for calc_tid (same cycle).
- mem_req_valid  out  1  request valid.
- mem_req_ready  in  1  memory accepts.
- mem_req_addr  out  ADDR_W  registered address.
- mem_req_lane  out  LANE_W  lane of this request.
- mem_req_tag  out  TAG_W  tag of owning instruction.
- mem_req_last  out  1  final request of instruction.
- done_valid  out  1  one-cycle completion pulse.
- done_tag  out  TAG_W  tag of completed instruction.

Behaviour:
- Reset (async, rst=0): state IDLE.
  - All outputs 0, except issue_ready=1.
  - Remaining mask R=0; scan pointer p=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - issue_ready=1.
  - On issue_valid&issue_ready: R<=issue_exec; tag<=issue_tag; p<=0.
  - If issue_exec==0, go to DONE; else go to RUN.
- RUN:
  - issue_ready=0.
  - calc_tid = candidate lane c (see Optional Feature).
  - Load condition: R[c]=1 and (!mem_req_valid | mem_req_ready).
  - On load:
    - mem_req_addr<=calc_addr; mem_req_lane<=c; mem_req_tag<=tag; mem_req_valid<=1.
    - R[c]<=0.
    - mem_req_last<=1 iff R with bit c cleared ==0.
  - mem_req_valid & !mem_req_ready: hold addr/lane/tag/last stable; no load.
  - Handshake with no load: mem_req_valid<=0.
  - Handshake with mem_req_last=1: go to DONE; mem_req_valid<=0.
- DONE:
  - done_valid=1 and done_tag=tag for exactly one cycle.
  - Then IDLE; issue_ready=1 in the following cycle.
- Latency: issue accepted at cycle T → first mem_req_valid at T+2. With back-to-back ready, one request per cycle thereafter.
- mem_req_ready is ignored when mem_req_valid=0.
- issue_valid is ignored outside IDLE; the upstream holds the instruction.
- Reset asserted mid-instruction: all state is discarded and no done pulse is emitted. The memory side must tolerate the dropped request.

Optional Feature:
- Macro: MTBUF_ADDR_SEQ_SKIP_EN.
- Defined:
  - c = lowest set bit of R (priority encoder).
  - Inactive lanes cost zero cycles; a mask of k active lanes completes in k+3 cycles with ready held high.
- Undefined:
  - c = p, a linear scan pointer.
  - p increments when R[p]=0 or on a load.
  - Every lane costs at least one cycle; wrap-around beyond lane 63 cannot occur because last is reached first.
- mem_req_* contents and ordering (ascending lane) are identical in both builds; only timing differs.

Decomposition:
- Shared package/defines: NUM_LANES, LANE_W, TAG_W, and the state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2 (alongside the existing LSU definitions).
- One sub-module: lane_prio_enc (64→6 lowest-set-bit encoder plus any-set flag), instantiated only under MTBUF_ADDR_SEQ_SKIP_EN.

Test Plan:
- exec=64'h1, calc_addr=0x1000+4*tid, ready=1 → one request lane 0, addr 0x1000, last=1; done pulse at T+3.
- exec=all ones, ready=1 → 64 requests, lanes 0..63 in order, addr 0x1000..0x10FC, last only on lane 63; with skip, done at T+66.
- exec=64'h8000_0000_0000_0001 → lanes 0 and 63 only; skip build takes 2 request cycles, non-skip build takes 64 scan cycles; same payloads.
- exec=0 → no mem_req_valid; done_valid pulse at T+1 with issue_tag; issue_ready back at T+2.
- exec=64'hF, ready toggling 1,0,0,1,… → addr/lane held stable while ready=0; no lane dropped or duplicated.
- Assert rst low in the middle of a 16-lane instruction → all outputs 0 immediately, issue_ready=1; no done pulse; next issue proceeds normally.

Source files
------------

// File: rtl/mtbuf_addr_seq_pkg.sv
// Shared definitions for the MTBUF address sequencer: lane/tag geometry and FSM encoding.
package mtbuf_addr_seq_pkg;

  localparam int unsigned NUM_LANES = 64;
  localparam int unsigned LANE_W    = 6;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned TAG_W     = 7;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } seq_state_e;

endpackage

// File: rtl/mtbuf_addr_seq_lane_prio_enc.sv
// Lowest-set-bit encoder over the remaining-lane mask; only built with MTBUF_ADDR_SEQ_SKIP_EN.
`ifdef MTBUF_ADDR_SEQ_SKIP_EN
module lane_prio_enc
  import mtbuf_addr_seq_pkg::*;
(
  input  logic [NUM_LANES-1:0] vec_i,
  output logic [LANE_W-1:0]    idx_o,
  output logic                 any_o
);

  // Scan high to low so the lowest set bit is the last assignment to win.
  always_comb begin
    idx_o = '0;
    any_o = |vec_i;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = LANE_W'(i);
    end
  end

endmodule
`endif

// File: rtl/mtbuf_addr_seq.sv
// MTBUF per-wavefront lane sequencer: walks active exec lanes and emits one address per request.
// MTBUF_ADDR_SEQ_SKIP_EN selects a priority-encoded lane pick instead of a linear scan.
module mtbuf_addr_seq
  import mtbuf_addr_seq_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 issue_valid_i,
  output logic                 issue_ready_o,
  input  logic [NUM_LANES-1:0] issue_exec_i,
  input  logic [TAG_W-1:0]     issue_tag_i,
  output logic [LANE_W-1:0]    calc_tid_o,
  input  logic [ADDR_W-1:0]    calc_addr_i,
  output logic                 mem_req_valid_o,
  input  logic                 mem_req_ready_i,
  output logic [ADDR_W-1:0]    mem_req_addr_o,
  output logic [LANE_W-1:0]    mem_req_lane_o,
  output logic [TAG_W-1:0]     mem_req_tag_o,
  output logic                 mem_req_last_o,
  output logic                 done_valid_o,
  output logic [TAG_W-1:0]     done_tag_o
);

  seq_state_e           state_q, state_d;
  logic [NUM_LANES-1:0] rem_q, rem_d, rem_clr;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic                 req_valid_q, req_valid_d;
  logic [ADDR_W-1:0]    req_addr_q, req_addr_d;
  logic [LANE_W-1:0]    req_lane_q, req_lane_d;
  logic [TAG_W-1:0]     req_tag_q, req_tag_d;
  logic                 req_last_q, req_last_d;
  logic [LANE_W-1:0]    cand;
  logic                 hit;
  logic                 can_load;

`ifdef MTBUF_ADDR_SEQ_SKIP_EN
  lane_prio_enc u_lane_prio_enc (
    .vec_i (rem_q),
    .idx_o (cand),
    .any_o (hit)
  );
`else
  logic [LANE_W-1:0] ptr_q, ptr_d;

  assign cand = ptr_q;
  assign hit  = rem_q[ptr_q];
`endif

  assign can_load = hit && (!req_valid_q || mem_req_ready_i);

  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    tag_d         = tag_q;
    req_valid_d   = req_valid_q;
    req_addr_d    = req_addr_q;
    req_lane_d    = req_lane_q;
    req_tag_d     = req_tag_q;
    req_last_d    = req_last_q;
    issue_ready_o = 1'b0;
    done_valid_o  = 1'b0;
    done_tag_o    = '0;
    calc_tid_o    = '0;
    rem_clr       = rem_q;
    rem_clr[cand] = 1'b0;
`ifndef MTBUF_ADDR_SEQ_SKIP_EN
    ptr_d         = ptr_q;
`endif
    case (state_q)
      StIdle: begin
        issue_ready_o = 1'b1;
        if (issue_valid_i) begin
          rem_d   = issue_exec_i;
          tag_d   = issue_tag_i;
          state_d = (issue_exec_i == '0) ? StDone : StRun;
`ifndef MTBUF_ADDR_SEQ_SKIP_EN
          ptr_d   = '0;
`endif
        end
      end
      StRun: begin
        calc_tid_o = cand;
        if (req_valid_q && mem_req_ready_i) begin
          req_valid_d = 1'b0;
          if (req_last_q) state_d = StDone;
        end
        if (can_load) begin
          req_valid_d = 1'b1;
          req_addr_d  = calc_addr_i;
          req_lane_d  = cand;
          req_tag_d   = tag_q;
          req_last_d  = (rem_clr == '0);
          rem_d       = rem_clr;
        end
`ifndef MTBUF_ADDR_SEQ_SKIP_EN
        // A stalled active lane holds the pointer until it is loaded.
        if (!hit || can_load) ptr_d = ptr_q + 1'b1;
`endif
      end
      StDone: begin
        done_valid_o = 1'b1;
        done_tag_o   = tag_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      rem_q       <= '0;
      tag_q       <= '0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_lane_q  <= '0;
      req_tag_q   <= '0;
      req_last_q  <= 1'b0;
`ifndef MTBUF_ADDR_SEQ_SKIP_EN
      ptr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      tag_q       <= tag_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      req_lane_q  <= req_lane_d;
      req_tag_q   <= req_tag_d;
      req_last_q  <= req_last_d;
`ifndef MTBUF_ADDR_SEQ_SKIP_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign mem_req_valid_o = req_valid_q;
  assign mem_req_addr_o  = req_addr_q;
  assign mem_req_lane_o  = req_lane_q;
  assign mem_req_tag_o   = req_tag_q;
  assign mem_req_last_o  = req_last_q;

endmodule

// File: tb/tb_mtbuf_addr_seq.sv
// Directed table-driven bench for mtbuf_addr_seq; honours MTBUF_ADDR_SEQ_SKIP_EN for timing.
module tb_mtbuf_addr_seq;
  import mtbuf_addr_seq_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 issue_valid;
  logic                 issue_ready;
  logic [NUM_LANES-1:0] issue_exec;
  logic [TAG_W-1:0]     issue_tag;
  logic [LANE_W-1:0]    calc_tid;
  logic [ADDR_W-1:0]    calc_addr;
  logic                 mem_req_valid;
  logic                 mem_req_ready;
  logic [ADDR_W-1:0]    mem_req_addr;
  logic [LANE_W-1:0]    mem_req_lane;
  logic [TAG_W-1:0]     mem_req_tag;
  logic                 mem_req_last;
  logic                 done_valid;
  logic [TAG_W-1:0]     done_tag;

  always #5 clk = ~clk;

  assign calc_addr = 32'h1000 + {24'h0, calc_tid, 2'b00};

  mtbuf_addr_seq dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .issue_valid_i   (issue_valid),
    .issue_ready_o   (issue_ready),
    .issue_exec_i    (issue_exec),
    .issue_tag_i     (issue_tag),
    .calc_tid_o      (calc_tid),
    .calc_addr_i     (calc_addr),
    .mem_req_valid_o (mem_req_valid),
    .mem_req_ready_i (mem_req_ready),
    .mem_req_addr_o  (mem_req_addr),
    .mem_req_lane_o  (mem_req_lane),
    .mem_req_tag_o   (mem_req_tag),
    .mem_req_last_o  (mem_req_last),
    .done_valid_o    (done_valid),
    .done_tag_o      (done_tag)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // mode 0: ready always high; mode 1: ready high only on cycles k where k%3==0
  typedef struct {
    logic [63:0] exec;
    logic [6:0]  tag;
    int          mode;
    int          done_cyc;
    int          first_cyc;
  } vec_t;

  // Cycle k is counted from the issue cycle (k=0); outputs are sampled on the falling edge.
  task automatic run_vec(input vec_t v);
    logic [45:0] exp_q[$];
    int total, seen, done_at, first_at, k;
    logic rdy;
    total = 0;
    for (int i = 0; i < 64; i++) if (v.exec[i]) total++;
    seen = 0;
    for (int i = 0; i < 64; i++) begin
      if (v.exec[i]) begin
        seen++;
        exp_q.push_back({(seen == total), v.tag, 6'(i), 32'h1000 + 32'(4 * i)});
      end
    end
    check("issue_ready before issue", 64'(issue_ready), 64'd1);
    issue_valid   = 1'b1;
    issue_exec    = v.exec;
    issue_tag     = v.tag;
    mem_req_ready = 1'b0;
    @(negedge clk);
    issue_valid = 1'b0;
    issue_exec  = '1;
    issue_tag   = '0;
    check("issue_ready busy", 64'(issue_ready), 64'd0);
    done_at  = -1;
    first_at = -1;
    k        = 1;
    while (done_at < 0 && k <= 200) begin
      if (mem_req_valid) begin
        if (first_at < 0) first_at = k;
        if (exp_q.size() == 0) check("extra request", 64'd1, 64'd0);
        else check("request payload",
                   64'({mem_req_last, mem_req_tag, mem_req_lane, mem_req_addr}), 64'(exp_q[0]));
      end
      if (done_valid) begin
        done_at = k;
        check("done tag", 64'(done_tag), 64'(v.tag));
      end
      rdy = (v.mode == 0) ? 1'b1 : ((k % 3) == 0);
      mem_req_ready = rdy;
      if (mem_req_valid && rdy && exp_q.size() > 0) void'(exp_q.pop_front());
      @(negedge clk);
      k++;
    end
    mem_req_ready = 1'b0;
    check("done cycle", 64'(done_at), 64'(v.done_cyc));
    check("first request cycle", 64'(first_at), 64'(v.first_cyc));
    check("requests outstanding", 64'(exp_q.size()), 64'd0);
    check("done pulse single", 64'(done_valid), 64'd0);
    check("issue_ready after done", 64'(issue_ready), 64'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " issue_ready"}, 64'(issue_ready), 64'd1);
    check({name, " outputs zero"},
          64'({mem_req_valid, mem_req_last, done_valid, calc_tid, mem_req_lane, mem_req_tag,
               done_tag}), 64'd0);
    check({name, " addr zero"}, 64'(mem_req_addr), 64'd0);
  endtask

  vec_t vecs[6];
  int   bad;

  initial begin
`ifdef MTBUF_ADDR_SEQ_SKIP_EN
    vecs[0] = '{64'h1,                   7'h05, 0, 3,  2};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 7'h11, 0, 66, 2};
    vecs[2] = '{64'h8000_0000_0000_0001, 7'h22, 0, 4,  2};
    vecs[3] = '{64'h0,                   7'h7F, 0, 1,  -1};
    vecs[4] = '{64'hF,                   7'h33, 1, 13, 2};
    vecs[5] = '{64'hA5,                  7'h44, 0, 6,  2};
`else
    vecs[0] = '{64'h1,                   7'h05, 0, 3,  2};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 7'h11, 0, 66, 2};
    vecs[2] = '{64'h8000_0000_0000_0001, 7'h22, 0, 66, 2};
    vecs[3] = '{64'h0,                   7'h7F, 0, 1,  -1};
    vecs[4] = '{64'hF,                   7'h33, 1, 13, 2};
    vecs[5] = '{64'hA5,                  7'h44, 0, 10, 2};
`endif
    rst_n         = 1'b0;
    issue_valid   = 1'b0;
    issue_exec    = '0;
    issue_tag     = '0;
    mem_req_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in the middle of a 16-lane instruction.
    issue_valid   = 1'b1;
    issue_exec    = 64'hFFFF;
    issue_tag     = 7'h55;
    mem_req_ready = 1'b1;
    @(negedge clk);
    issue_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid-run request active", 64'(mem_req_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    bad   = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_valid || mem_req_valid || !issue_ready) bad++;
    end
    mem_req_ready = 1'b0;
    check("quiet after reset", 64'(bad), 64'd0);
    run_vec(vecs[0]);
    run_vec(vecs[5]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
